// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - store/load size encodings, access FSM states and timeout default.
package pipeline_pkg;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      MEM_BYTE: store_be = 4'b0001 << offset;
      MEM_HALF: store_be = offset[1] ? 4'b1100 : 4'b0011;
      default:  store_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - picks the addressed byte/half lane of a read word and extends it.
module load_extend import pipeline_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            size,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{offset, 3'b000} +: 8];
    lane_h = rdata[{offset[1], 4'b0000} +: 16];
    case (size)
      F3_LB:   data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      F3_LH:   data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store sequencer: captures an access, holds the
// memory request until ack or timeout, then returns the extended load result.
module mem_access_unit import pipeline_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               MemWriteM_i,
  input  logic                     MemReadM_i,
  input  logic [2:0]               LoadSizeM_i,
  input  logic [ADDRESS_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]    WriteDataM_i,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  output logic [3:0]               mem_be_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  output logic [DATA_WIDTH-1:0]    ReadDataW_o,
  output logic                     StallM_o,
  output logic                     valid_o,
  output logic                     misaligned_o,
  output logic                     bus_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state;
  logic [CW-1:0]         wait_cnt;
  logic [2:0]            ld_size_q;
  logic [1:0]            offset_q;
  logic                  is_load_q;
  logic                  is_store;
  logic                  access;
  logic                  misaligned;
  logic [1:0]            acc_size;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] ext_data;

  // A simultaneous store and load request is handled as the store.
  always_comb begin
    is_store = (MemWriteM_i != MEM_NONE);
    access   = is_store || MemReadM_i;
    if (is_store) begin
      acc_size = MemWriteM_i;
    end else begin
      case (LoadSizeM_i)
        F3_LB, F3_LBU: acc_size = MEM_BYTE;
        F3_LH, F3_LHU: acc_size = MEM_HALF;
        default:       acc_size = MEM_WORD;
      endcase
    end
    misaligned = access && (((acc_size == MEM_HALF) && ALUResultM_i[0]) ||
                            ((acc_size == MEM_WORD) && (ALUResultM_i[1:0] != 2'b00)));
    case (MemWriteM_i)
      MEM_BYTE: wdata_rep = {(DATA_WIDTH/8){WriteDataM_i[7:0]}};
      MEM_HALF: wdata_rep = {(DATA_WIDTH/16){WriteDataM_i[15:0]}};
      default:  wdata_rep = WriteDataM_i;
    endcase
  end

  assign StallM_o = (state == S_REQ) || ((state == S_IDLE) && access && !misaligned);

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .size   (ld_size_q),
    .offset (offset_q),
    .rdata  (mem_rdata_i),
    .data   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      ld_size_q    <= '0;
      offset_q     <= '0;
      is_load_q    <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= 4'b0000;
      ReadDataW_o  <= '0;
      valid_o      <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      valid_o      <= 1'b0;
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access && misaligned) begin
            misaligned_o <= 1'b1;
          end else if (access) begin
            mem_addr_o  <= {ALUResultM_i[ADDRESS_WIDTH-1:2], 2'b00};
            mem_be_o    <= is_store ? store_be(MemWriteM_i, ALUResultM_i[1:0]) : 4'b1111;
            mem_wdata_o <= wdata_rep;
            mem_we_o    <= is_store;
            mem_req_o   <= 1'b1;
            is_load_q   <= !is_store;
            ld_size_q   <= LoadSizeM_i;
            offset_q    <= ALUResultM_i[1:0];
            wait_cnt    <= '0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            valid_o   <= 1'b1;
            if (is_load_q) ReadDataW_o <= ext_data;
            state     <= S_DONE;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            valid_o     <= 1'b1;
            bus_err_o   <= 1'b1;
            ReadDataW_o <= '0;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
